la_vmux4_arb: RTL and testbench
===============================

Name: la_vmux4_arb

Overview:
- Round-robin arbiter that shares one N-bit output channel among 4 valid/ready requesters.
- Generates a one-hot select, steers the winner's data through an AND-OR one-hot mux, and registers the result in a single output slice.
- Sits in front of any shared datapath resource (bus, port, FIFO write side) that accepts one word per cycle.

Parameters:
- N, 1, data width per requester and output
- PROP, "DEFAULT", cell property string, passed through to the select/mux logic

Ports:
- clk  input  1  clock; all state on rising edge
- nreset  input  1  asynchronous active-low reset
- in_valid  input  4  request valid, bit i for requester i
- in_ready  output  4  request accepted this cycle; at most one bit high
- in3  input  N  requester 3 data
- in2  input  N  requester 2 data
- in1  input  N  requester 1 data
- in0  input  N  requester 0 data
- out_valid  output  1  registered output valid
- out_ready  input  1  downstream accepts output
- out  output  N  registered selected data
- out_sel  output  4  registered one-hot source of current out; 0 when out_valid=0

Behaviour:
- Reset (async, nreset=0): out_valid=0, out=0, out_sel=0, ptr=0. Because in_ready is combinational, in_ready=0 whenever out_valid=0 and in_valid=0.
- slot_free = ~out_valid | out_ready.
- ptr: 2-bit priority pointer. Requester ptr has highest priority, then ptr+1, ptr+2, ptr+3 (mod 4).
- gnt_c: one-hot pick of the first set in_valid bit in priority order; 0 if in_valid=0.
- in_ready = gnt_c & {4{slot_free}}. It depends combinationally on in_valid and out_ready; no path from in_ready to in_valid is allowed.
- Accept (slot_free & |in_valid):
  - out <= AND-OR of gnt_c with in3..in0
  - out_sel <= gnt_c
  - out_valid <= 1
  - ptr <= winner+1 mod 4
- No accept and out_ready=1: out_valid <= 0, out_sel <= 0. out holds its last value.
- No accept and out_ready=0: all registers hold. Stalled output data is stable.
- Latency: input accept to out_valid is 1 cycle.
- Throughput: 1 word/cycle. Simultaneous out_ready and new accept reloads the slot in the same edge, with no bubble.
- Single requester continuously valid: it wins every cycle. Pointer wraps 3 -> 0.
- Requester dropping in_valid without handshake: legal; it is not granted that cycle.
- Reset asserted mid-transfer: the output word is discarded. After release, arbitration restarts with priority at requester 0.

Optional Feature:
- Macro: LA_VMUX4_ARB_LOCK_EN.
- When defined:
  - Adds port in_last input 4, marking the last beat of a packet.
  - Adds a lock flag and lock owner register, both reset to 0.
  - When a beat with in_last[w]=0 is accepted, lock is set and owner=w; ptr does not advance.
  - While locked: gnt_c = owner one-hot only, and in_ready[owner] = slot_free regardless of in_valid. Other requesters are starved until the owner's in_last beat is accepted. That accept clears lock and sets ptr=owner+1.
  - Single-beat packets (in_last=1) behave exactly as the unlocked design.
- When not defined: no in_last port; every beat is arbitrated independently.

Decomposition:
- Shared package/header: requester count localparam (4) and the pointer width (2).
- Sub-module la_rrpick4: combinational round-robin priority picker. Inputs are request[3:0] and ptr[1:0]; outputs are one-hot gnt[3:0] and the encoded winner[1:0].
- Top level holds: the pointer, the output slice, the lock logic, and the AND-OR data mux.

Test Plan (N=8):
- Reset: nreset=0 mid-stream with out_valid=1 -> out_valid=0, out_sel=0, out=0 immediately (async). First grant after release goes to requester 0 when all are valid.
- Fairness: in_valid=4'b1111 held, out_ready=1, in0..in3=8'h10,8'h11,8'h12,8'h13 -> out sequence 10,11,12,13,10 on consecutive cycles, one in_ready bit per cycle.
- Backpressure: out_ready=0 for 3 cycles after out=8'hA5 -> out, out_sel and out_valid stable, in_ready=0. On out_ready=1 the next word loads with no bubble.
- Sparse requests: only in_valid[2] set with in2=8'h3C, then only in_valid[1] -> out 3C (out_sel=4'b0100), then in1 data. Pointer after the first grant is 3.
- Drain: single accept then in_valid=0, out_ready=1 -> out_valid drops the cycle after the handshake, out_sel=0.
- Lock (LA_VMUX4_ARB_LOCK_EN defined): requester 1 sends 3 beats with in_last=0,0,1 while requester 0 stays valid -> three requester-1 beats back to back, then requester 2/3/0 per round-robin order. Requester 1 idling mid-packet blocks all others.

Source files
------------

// File: rtl/la_vmux4_arb_pkg.sv
// Shared constants and helpers for the 4-way round-robin arbiter/mux.
package la_vmux4_arb_pkg;

   localparam int unsigned NumReq = 4;
   localparam int unsigned PtrW   = 2;

   typedef logic [NumReq-1:0] req_t;
   typedef logic [PtrW-1:0]   ptr_t;

   function automatic req_t idx_to_onehot(ptr_t idx);
      req_t oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/la_vmux4_arb_if.sv
// Requester and output channel bundle for la_vmux4_arb.
// in_last exists only when LA_VMUX4_ARB_LOCK_EN is defined.
interface la_vmux4_arb_if #(
   parameter int unsigned N = 1
) ();
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [N-1:0] in3;
   logic [N-1:0] in2;
   logic [N-1:0] in1;
   logic [N-1:0] in0;
`ifdef LA_VMUX4_ARB_LOCK_EN
   logic [3:0]   in_last;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out;
   logic [3:0]   out_sel;

   modport master (
      output in_valid, in3, in2, in1, in0,
`ifdef LA_VMUX4_ARB_LOCK_EN
      output in_last,
`endif
      output out_ready,
      input  in_ready, out_valid, out, out_sel
   );

   modport slave (
      input  in_valid, in3, in2, in1, in0,
`ifdef LA_VMUX4_ARB_LOCK_EN
      input  in_last,
`endif
      input  out_ready,
      output in_ready, out_valid, out, out_sel
   );
endinterface

// File: rtl/la_rrpick4.sv
// Combinational 4-way round-robin picker: requester ptr has top priority.
module la_rrpick4
   import la_vmux4_arb_pkg::*;
#(
   parameter string PROP = "DEFAULT"
) (
   input  req_t request,
   input  ptr_t ptr,
   output req_t gnt,
   output ptr_t winner
);

   logic found;
   ptr_t idx;

   always_comb begin
      gnt    = '0;
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         idx = ptr + PtrW'(i);
         if (!found && request[idx]) begin
            gnt[idx] = 1'b1;
            winner   = idx;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/la_vmux4_arb.sv
// Round-robin arbiter sharing one registered N-bit output slice among 4 requesters.
// Define LA_VMUX4_ARB_LOCK_EN to hold the grant across multi-beat packets (in_last).
module la_vmux4_arb
   import la_vmux4_arb_pkg::*;
#(
   parameter int unsigned N    = 1,
   parameter string       PROP = "DEFAULT"
) (
   input logic           clk,
   input logic           nreset,
   la_vmux4_arb_if.slave bus
);

   logic         out_valid_q, out_valid_d;
   logic [N-1:0] out_q, out_d;
   req_t         out_sel_q, out_sel_d;
   ptr_t         ptr_q, ptr_d;

   req_t         pick_gnt;
   ptr_t         pick_winner;
   req_t         gnt_c;
   ptr_t         winner;
   req_t         in_ready;
   logic         slot_free;
   logic         accept;
   logic [N-1:0] mux_data;
   logic [N-1:0] in_data [NumReq];

`ifdef LA_VMUX4_ARB_LOCK_EN
   logic lock_q, lock_d;
   ptr_t owner_q, owner_d;
`endif

   assign in_data[0] = bus.in0;
   assign in_data[1] = bus.in1;
   assign in_data[2] = bus.in2;
   assign in_data[3] = bus.in3;

   la_rrpick4 #(
      .PROP(PROP)
   ) u_pick (
      .request(bus.in_valid),
      .ptr    (ptr_q),
      .gnt    (pick_gnt),
      .winner (pick_winner)
   );

   always_comb begin
      slot_free = ~out_valid_q | bus.out_ready;
      gnt_c     = pick_gnt;
      winner    = pick_winner;
      accept    = slot_free & (|bus.in_valid);
`ifdef LA_VMUX4_ARB_LOCK_EN
      // While locked the owner is offered the slot even when it is idle.
      if (lock_q) begin
         gnt_c  = idx_to_onehot(owner_q);
         winner = owner_q;
         accept = slot_free & bus.in_valid[owner_q];
      end
`endif
      in_ready = gnt_c & {NumReq{slot_free}};
   end

   always_comb begin
      mux_data = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         mux_data = mux_data | (in_data[i] & {N{gnt_c[i]}});
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_d       = out_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
`ifdef LA_VMUX4_ARB_LOCK_EN
      lock_d      = lock_q;
      owner_d     = owner_q;
`endif
      if (accept) begin
         out_valid_d = 1'b1;
         out_d       = mux_data;
         out_sel_d   = gnt_c;
         ptr_d       = winner + ptr_t'(1);
`ifdef LA_VMUX4_ARB_LOCK_EN
         if (!bus.in_last[winner]) begin
            lock_d  = 1'b1;
            owner_d = winner;
            ptr_d   = ptr_q;
         end else begin
            lock_d  = 1'b0;
         end
`endif
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
         out_sel_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
`ifdef LA_VMUX4_ARB_LOCK_EN
         lock_q      <= 1'b0;
         owner_q     <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
`ifdef LA_VMUX4_ARB_LOCK_EN
         lock_q      <= lock_d;
         owner_q     <= owner_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;
   assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_la_vmux4_arb.sv
// Directed self-checking bench for la_vmux4_arb (N=8); lock vectors run with LA_VMUX4_ARB_LOCK_EN.
module tb_la_vmux4_arb;

   logic clk;
   logic nreset;
   int   n_tests;
   int   n_fail;

   la_vmux4_arb_if #(.N(8)) bus ();

   la_vmux4_arb #(
      .N   (8),
      .PROP("DEFAULT")
   ) dut (
      .clk   (clk),
      .nreset(nreset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [3:0] sel,
                          input logic [7:0] data);
      check_eq({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
      check_eq({tag, ".sel"}, 32'(bus.out_sel), 32'(sel));
      check_eq({tag, ".data"}, 32'(bus.out), 32'(data));
   endtask

   task automatic chk_rdy(input string tag, input logic [3:0] exp);
      check_eq({tag, ".ready"}, 32'(bus.in_ready), 32'(exp));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      nreset = 1'b0;
      #1;
      nreset = 1'b1;
      #1;
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      nreset        = 1'b0;
      bus.in_valid  = 4'b0000;
      bus.out_ready = 1'b0;
      bus.in0       = 8'h00;
      bus.in1       = 8'h00;
      bus.in2       = 8'h00;
      bus.in3       = 8'h00;
`ifdef LA_VMUX4_ARB_LOCK_EN
      bus.in_last   = 4'b1111;
`endif
      #3;
      chk_out("rst", 1'b0, 4'b0000, 8'h00);
      chk_rdy("rst", 4'b0000);
      step();
      step();
      nreset = 1'b1;

      // Fairness: all valid, rotating 0,1,2,3,0
      bus.out_ready = 1'b1;
      bus.in0 = 8'h10;
      bus.in1 = 8'h11;
      bus.in2 = 8'h12;
      bus.in3 = 8'h13;
      bus.in_valid = 4'b1111;
      #1;
      chk_rdy("fair0", 4'b0001);
      for (int k = 0; k < 5; k++) begin
         step();
         chk_out("fair", 1'b1, 4'(1 << (k % 4)), 8'(8'h10 + (k % 4)));
         chk_rdy("fair", 4'(1 << ((k + 1) % 4)));
      end

      // Backpressure: A5 held for 3 stalled cycles, then reload without bubble
      bus.in_valid = 4'b0010;
      bus.in1 = 8'hA5;
      step();
      chk_out("bp_load", 1'b1, 4'b0010, 8'hA5);
      bus.out_ready = 1'b0;
      bus.in_valid = 4'b1111;
      bus.in1 = 8'h11;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk_rdy("bp_stall", 4'b0000);
         step();
         chk_out("bp_stall", 1'b1, 4'b0010, 8'hA5);
      end
      bus.out_ready = 1'b1;
      #1;
      chk_rdy("bp_go", 4'b0100);
      step();
      chk_out("bp_go", 1'b1, 4'b0100, 8'h12);

      // Async reset mid-stream, then priority restarts at requester 0
      #1;
      nreset = 1'b0;
      #1;
      chk_out("midrst", 1'b0, 4'b0000, 8'h00);
      chk_rdy("midrst", 4'b0001);
      step();
      nreset = 1'b1;
      step();
      chk_out("post_rst", 1'b1, 4'b0001, 8'h10);

      // Drain
      bus.in_valid = 4'b0000;
      step();
      chk_out("drain", 1'b0, 4'b0000, 8'h10);
      chk_rdy("drain", 4'b0000);

      // Sparse requests from fresh pointer
      pulse_reset();
      bus.in_valid = 4'b0100;
      bus.in2 = 8'h3C;
      #1;
      chk_rdy("sparse2", 4'b0100);
      step();
      chk_out("sparse2", 1'b1, 4'b0100, 8'h3C);
      bus.in_valid = 4'b1011;
      #1;
      chk_rdy("ptr3a", 4'b1000);
      bus.in_valid = 4'b0111;
      #1;
      chk_rdy("ptr3b", 4'b0001);
      bus.in_valid = 4'b0010;
      bus.in1 = 8'h5A;
      #1;
      chk_rdy("sparse1", 4'b0010);
      step();
      chk_out("sparse1", 1'b1, 4'b0010, 8'h5A);
      bus.in_valid = 4'b0000;
      step();
      chk_out("sparse_drain", 1'b0, 4'b0000, 8'h5A);

`ifdef LA_VMUX4_ARB_LOCK_EN
      // Requester 1 sends a 3-beat packet while requester 0 keeps requesting
      pulse_reset();
      bus.in_last = 4'b1111;
      bus.in_valid = 4'b0001;
      bus.in0 = 8'h20;
      step();
      chk_out("lk_pre", 1'b1, 4'b0001, 8'h20);
      bus.in_valid = 4'b0011;
      bus.in1 = 8'h21;
      bus.in_last = 4'b1101;
      #1;
      chk_rdy("lk_b0", 4'b0010);
      step();
      chk_out("lk_b0", 1'b1, 4'b0010, 8'h21);
      bus.in1 = 8'h22;
      #1;
      chk_rdy("lk_b1", 4'b0010);
      step();
      chk_out("lk_b1", 1'b1, 4'b0010, 8'h22);
      bus.in_valid = 4'b0001;
      #1;
      chk_rdy("lk_idle", 4'b0010);
      step();
      chk_out("lk_idle", 1'b0, 4'b0000, 8'h22);
      bus.in_valid = 4'b0011;
      bus.in1 = 8'h23;
      bus.in_last = 4'b1111;
      step();
      chk_out("lk_b2", 1'b1, 4'b0010, 8'h23);
      bus.in_valid = 4'b1101;
      bus.in0 = 8'h30;
      bus.in2 = 8'h32;
      bus.in3 = 8'h33;
      step();
      chk_out("lk_rr2", 1'b1, 4'b0100, 8'h32);
      step();
      chk_out("lk_rr3", 1'b1, 4'b1000, 8'h33);
      step();
      chk_out("lk_rr0", 1'b1, 4'b0001, 8'h30);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
